mdu: RTL and testbench

Multi-cycle multiply/divide unit for the pipelined CPU, sitting beside the single-cycle ALU in the EX stage. It executes `mult`, `multu`, `div` and `divu` over a fixed number of cycles and holds the results in architectural HI/LO registers. It also services `mthi` and `mtlo`, and exposes HI/LO for `mfhi` and `mflo`. Hazard logic in decode stalls MDU-class instructions using `Start | Busy`.

---
 rtl/mdu_if.sv | 13 +
 rtl/mdu.sv | 119 +++++++++++
 tb/tb_mdu.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - request/result bundle between the EX stage and the multiply/divide unit
interface mdu_if;
  logic        Start;
  logic [2:0]  MduOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MduOp, A, B, input Busy, HI, LO);
  modport slave  (input Start, MduOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit owning the HI/LO registers
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  logic [31:0] div_q, div_r, divu_q, divu_r;
  logic        b_zero;

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally.
  always_comb begin
    b_zero = (b_q == 32'd0);
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    a_mag  = a_q[31] ? (32'd0 - a_q) : a_q;
    b_mag  = b_q[31] ? (32'd0 - b_q) : b_q;
    q_mag  = b_zero ? 32'd0 : (a_mag / b_mag);
    r_mag  = b_zero ? 32'd0 : (a_mag % b_mag);
    div_q  = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
    div_r  = a_q[31] ? (32'd0 - r_mag) : r_mag;
    divu_q = b_zero ? 32'd0 : (a_q / b_q);
    divu_r = b_zero ? 32'd0 : (a_q % b_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= 3'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      busy_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            case (bus.MduOp)
              OP_MULT, OP_MULTU: begin
                op_q   <= bus.MduOp;
                a_q    <= bus.A;
                b_q    <= bus.B;
                cnt    <= CW'(MULT_CYCLES);
                busy_q <= 1'b1;
                state  <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                op_q   <= bus.MduOp;
                a_q    <= bus.A;
                b_q    <= bus.B;
                cnt    <= CW'(DIV_CYCLES);
                busy_q <= 1'b1;
                state  <= RUN;
              end
              OP_MTHI: hi_q <= bus.A;
              OP_MTLO: lo_q <= bus.A;
              default: ;
            endcase
          end
        end
        RUN: begin
          // Start is deliberately not looked at here; decode owns the interlock.
          if (cnt == CW'(1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            case (op_q)
              OP_MULT:  {hi_q, lo_q} <= prod_s;
              OP_MULTU: {hi_q, lo_q} <= prod_u;
              OP_DIV: if (!b_zero) begin
                hi_q <= div_r;
                lo_q <= div_q;
              end
              OP_DIVU: if (!b_zero) begin
                hi_q <= divu_r;
                lo_q <= divu_q;
              end
              default: ;
            endcase
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed self-checking bench for the multiply/divide unit
module tb_mdu;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  mdu_if bus ();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.MduOp = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    bus.MduOp = 3'd0;
  endtask

  // Counts cycles with Busy high, bounded so a stuck Busy shows up as a wrong count.
  task automatic wait_busy(output int cycles);
    cycles = 0;
    while (bus.Busy && cycles < 50) begin
      cycles++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.Start = 1'b1; bus.MduOp = 3'd1; bus.A = 32'd3; bus.B = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    n_cmp++; if (bus.HI !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %h want 00000000", bus.HI); end
    n_cmp++; if (bus.LO !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %h want 00000000", bus.LO); end
    bus.Start = 1'b0; bus.MduOp = 3'd0;
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", bus.Busy); end
  endtask

  task automatic test_mult;
    issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0003);
    wait_busy(cyc);
    n_cmp++; if (cyc != 5) begin n_bad++; $display("FAIL mult_cycles: got %0d want 5", cyc); end
    n_cmp++; if (bus.HI !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", bus.HI); end
    n_cmp++; if (bus.LO !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL mult_lo: got %h want fffffffd", bus.LO); end
    issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0003);
    wait_busy(cyc);
    n_cmp++; if (cyc != 5) begin n_bad++; $display("FAIL multu_cycles: got %0d want 5", cyc); end
    n_cmp++; if (bus.HI !== 32'h0000_0002) begin n_bad++; $display("FAIL multu_hi: got %h want 00000002", bus.HI); end
    n_cmp++; if (bus.LO !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL multu_lo: got %h want fffffffd", bus.LO); end
  endtask

  task automatic test_div;
    issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_busy(cyc);
    n_cmp++; if (cyc != 10) begin n_bad++; $display("FAIL div_cycles: got %0d want 10", cyc); end
    n_cmp++; if (bus.LO !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo: got %h want fffffffd", bus.LO); end
    n_cmp++; if (bus.HI !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi: got %h want ffffffff", bus.HI); end
    issue(3'd4, 32'd7, 32'd2);
    wait_busy(cyc);
    n_cmp++; if (cyc != 10) begin n_bad++; $display("FAIL divu_cycles: got %0d want 10", cyc); end
    n_cmp++; if (bus.LO !== 32'd3) begin n_bad++; $display("FAIL divu_lo: got %h want 00000003", bus.LO); end
    n_cmp++; if (bus.HI !== 32'd1) begin n_bad++; $display("FAIL divu_hi: got %h want 00000001", bus.HI); end
  endtask

  task automatic test_div_edge;
    issue(3'd5, 32'h0000_0011, 32'd0);
    n_cmp++; if (bus.HI !== 32'h11) begin n_bad++; $display("FAIL mthi_hi: got %h want 00000011", bus.HI); end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy: got %b want 0", bus.Busy); end
    issue(3'd6, 32'h0000_0022, 32'd0);
    n_cmp++; if (bus.LO !== 32'h22) begin n_bad++; $display("FAIL mtlo_lo: got %h want 00000022", bus.LO); end
    n_cmp++; if (bus.HI !== 32'h11) begin n_bad++; $display("FAIL mtlo_hi_kept: got %h want 00000011", bus.HI); end
    issue(3'd4, 32'd5, 32'd0);
    wait_busy(cyc);
    n_cmp++; if (cyc != 10) begin n_bad++; $display("FAIL divzero_cycles: got %0d want 10", cyc); end
    n_cmp++; if (bus.HI !== 32'h11) begin n_bad++; $display("FAIL divzero_hi: got %h want 00000011", bus.HI); end
    n_cmp++; if (bus.LO !== 32'h22) begin n_bad++; $display("FAIL divzero_lo: got %h want 00000022", bus.LO); end
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy(cyc);
    n_cmp++; if (bus.LO !== 32'h8000_0000) begin n_bad++; $display("FAIL divovf_lo: got %h want 80000000", bus.LO); end
    n_cmp++; if (bus.HI !== 32'd0) begin n_bad++; $display("FAIL divovf_hi: got %h want 00000000", bus.HI); end
  endtask

  task automatic test_ignored_start;
    issue(3'd1, 32'd6, 32'd7);
    cyc = 1;
    bus.Start = 1'b1; bus.MduOp = 3'd6; bus.A = 32'h0000_DEAD; bus.B = 32'd9;
    @(posedge clk); #1;
    bus.Start = 1'b0; bus.MduOp = 3'd0; bus.A = 32'h1234_5678;
    n_cmp++; if (bus.LO !== 32'h8000_0000) begin n_bad++; $display("FAIL ignored_mtlo_lo: got %h want 80000000", bus.LO); end
    n_cmp++; if (bus.Busy !== 1'b1) begin n_bad++; $display("FAIL ignored_busy: got %b want 1", bus.Busy); end
    while (bus.Busy && cyc < 50) begin
      cyc++;
      @(posedge clk); #1;
    end
    n_cmp++; if (cyc != 5) begin n_bad++; $display("FAIL ignored_cycles: got %0d want 5", cyc); end
    n_cmp++; if (bus.LO !== 32'd42) begin n_bad++; $display("FAIL latched_lo: got %h want 0000002a", bus.LO); end
    n_cmp++; if (bus.HI !== 32'd0) begin n_bad++; $display("FAIL latched_hi: got %h want 00000000", bus.HI); end
  endtask

  task automatic test_back_to_back;
    issue(3'd4, 32'd100, 32'd7);
    wait_busy(cyc);
    n_cmp++; if (bus.LO !== 32'd14) begin n_bad++; $display("FAIL b2b_first_lo: got %h want 0000000e", bus.LO); end
    n_cmp++; if (bus.HI !== 32'd2) begin n_bad++; $display("FAIL b2b_first_hi: got %h want 00000002", bus.HI); end
    issue(3'd2, 32'h0001_0000, 32'h0001_0000);
    n_cmp++; if (bus.Busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got %b want 1", bus.Busy); end
    wait_busy(cyc);
    n_cmp++; if (cyc != 5) begin n_bad++; $display("FAIL b2b_cycles: got %0d want 5", cyc); end
    n_cmp++; if (bus.HI !== 32'd1) begin n_bad++; $display("FAIL b2b_hi: got %h want 00000001", bus.HI); end
    n_cmp++; if (bus.LO !== 32'd0) begin n_bad++; $display("FAIL b2b_lo: got %h want 00000000", bus.LO); end
  endtask

  task automatic test_mid_reset;
    issue(3'd3, 32'd100, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", bus.Busy); end
    n_cmp++; if (bus.HI !== 32'd0) begin n_bad++; $display("FAIL midrst_hi: got %h want 00000000", bus.HI); end
    n_cmp++; if (bus.LO !== 32'd0) begin n_bad++; $display("FAIL midrst_lo: got %h want 00000000", bus.LO); end
    repeat (12) @(posedge clk);
    #1;
    n_cmp++; if (bus.LO !== 32'd0 || bus.HI !== 32'd0) begin n_bad++; $display("FAIL midrst_nocommit: got hi %h lo %h want 0/0", bus.HI, bus.LO); end
    issue(3'd5, 32'h0000_1234, 32'd0);
    n_cmp++; if (bus.HI !== 32'h1234) begin n_bad++; $display("FAIL post_mthi_hi: got %h want 00001234", bus.HI); end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL post_mthi_busy: got %b want 0", bus.Busy); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    bus.Start = 1'b0;
    bus.MduOp = 3'd0;
    bus.A = 32'd0;
    bus.B = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_div_edge();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
